xy_wormhole_router: RTL and testbench



---
 rtl/xy_wormhole_router.sv | 276 +++++++++++++++++++++++++++
 tb/tb_xy_wormhole_router.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_wormhole_router.sv
// rtl/xy_wormhole_router.sv - XY-routed wormhole mesh router with per-input FIFOs
//
// Purpose:
//   Mesh NoC router. Every input channel buffers flits in its own FIFO, computes
//   an XY route from the header at the FIFO head and requests one output of an
//   N x N crossbar. Each output owns a round-robin arbiter that stays locked to
//   its winner until that packet's TLAST flit leaves. Packets with unreachable
//   destinations are popped and discarded, and counted in drop_cnt.
//
// Channel map: 0 NORTH (y-1), 1 SOUTH (y+1), 2 EAST (x+1), 3 WEST (x-1),
//              4..4+LOCAL_PORTS-1 LOCAL ports.
//
// Ports:
//   clk, rst_n                      single clock, synchronous active-low reset
//   in_tdata/in_tlast/in_tvalid     input flit streams, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_tready                       input FIFO not full (forced low during reset)
//   out_tdata/out_tlast/out_tvalid  output flit streams, driven from the granted FIFO head
//   out_tready                      downstream ready per output
//   drop_cnt                        saturating count of discarded packets

module xy_wormhole_router #(
  parameter int DATA_WIDTH     = 32,
  parameter int LOCAL_PORTS    = 1,
  parameter int BUFFER_LENGTH  = 16,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  localparam int CHANNEL_NUMBER = 4 + LOCAL_PORTS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata,
  input  logic [CHANNEL_NUMBER-1:0]            in_tlast,
  input  logic [CHANNEL_NUMBER-1:0]            in_tvalid,
  output logic [CHANNEL_NUMBER-1:0]            in_tready,
  output logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] out_tdata,
  output logic [CHANNEL_NUMBER-1:0]            out_tlast,
  output logic [CHANNEL_NUMBER-1:0]            out_tvalid,
  input  logic [CHANNEL_NUMBER-1:0]            out_tready,
  output logic [15:0]                          drop_cnt
);

  localparam int CN = CHANNEL_NUMBER;
  localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
  localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
  localparam int LW = (LOCAL_PORTS > 1) ? $clog2(LOCAL_PORTS) : 1;
  localparam int AD = XW + YW + LW;
  localparam int CW = $clog2(CN);
  localparam int AW = $clog2(BUFFER_LENGTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(BUFFER_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FWD, S_DROP} state_t;

  // Returns {route_ok, output_channel} for a header address field.
  function automatic logic [CW:0] route_of(input logic [AD-1:0] addr, input int self);
    int   dx;
    int   dy;
    int   dl;
    int   dir;
    logic ok;
    dx  = int'(addr[XW-1:0]);
    dy  = int'(addr[XW +: YW]);
    dl  = int'(addr[XW+YW +: LW]);
    ok  = 1'b1;
    dir = 0;
    if (dx >= MAX_ROUTERS_X || dy >= MAX_ROUTERS_Y || dl >= LOCAL_PORTS) ok = 1'b0;
    if (dx > ROUTER_X) begin
      dir = 2;
      if (ROUTER_X >= MAX_ROUTERS_X - 1) ok = 1'b0;
    end else if (dx < ROUTER_X) begin
      dir = 3;
      if (ROUTER_X == 0) ok = 1'b0;
    end else if (dy > ROUTER_Y) begin
      dir = 1;
      if (ROUTER_Y >= MAX_ROUTERS_Y - 1) ok = 1'b0;
    end else if (dy < ROUTER_Y) begin
      dir = 0;
      if (ROUTER_Y == 0) ok = 1'b0;
    end else begin
      dir = 4 + dl;
    end
    // A packet may never leave on the channel it arrived on.
    if (dir == self) ok = 1'b0;
    return {ok, dir[CW-1:0]};
  endfunction

  // Returns {found, winner}, searching from ptr+1 and wrapping.
  function automatic logic [CW:0] rr_pick(input logic [CN-1:0] req, input logic [CW-1:0] ptr);
    logic [CW:0] r;
    int          idx;
    r = '0;
    for (int k = 1; k <= CN; k++) begin
      idx = (int'(ptr) + k) % CN;
      if (!r[CW] && req[idx]) r = {1'b1, idx[CW-1:0]};
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] head_data  [CN];
  logic                  head_last  [CN];
  logic                  fifo_empty [CN];
  logic                  route_ok   [CN];
  logic [CW-1:0]         route_dir  [CN];
  logic [CW-1:0]         route_reg  [CN];
  state_t                state      [CN];
  state_t                state_nx   [CN];
  logic                  fwd_pop    [CN];
  logic                  want       [CN];
  logic [CW-1:0]         want_dir   [CN];

  logic                  grant_valid [CN];
  logic [CW-1:0]         grant_idx   [CN];
  logic [CW-1:0]         rr_ptr      [CN];
  logic [CN-1:0]         req         [CN];
  logic [CW:0]           pick        [CN];

  logic [CW:0]           drop_inc;
  logic [16:0]           drop_sum;

  // ------------------------------------------------------------------
  // Per-input FIFO, route computation and packet FSM
  // ------------------------------------------------------------------
  for (genvar i = 0; i < CN; i++) begin : g_in
    logic [DATA_WIDTH:0] mem [BUFFER_LENGTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                push;
    logic                pop;
    logic [CW:0]         rt;

    assign in_tready[i]  = rst_n && (count != FULL_CNT);
    assign push          = in_tvalid[i] && in_tready[i];
    assign fifo_empty[i] = (count == '0);
    assign pop           = fwd_pop[i] || (state[i] == S_DROP && !fifo_empty[i]);
    assign head_data[i]  = mem[rd_ptr][DATA_WIDTH-1:0];
    assign head_last[i]  = mem[rd_ptr][DATA_WIDTH];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_tlast[i], in_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end

    // The head is only interpreted as a header while the FSM is IDLE.
    assign rt           = route_of(head_data[i][AD-1:0], i);
    assign route_ok[i]  = rt[CW];
    assign route_dir[i] = rt[CW-1:0];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state[i]     <= S_IDLE;
        route_reg[i] <= '0;
      end else begin
        state[i] <= state_nx[i];
        if (state[i] == S_IDLE && !fifo_empty[i] && route_ok[i]) route_reg[i] <= route_dir[i];
      end
    end

    always_comb begin
      state_nx[i] = state[i];
      case (state[i])
        S_IDLE: if (!fifo_empty[i]) state_nx[i] = route_ok[i] ? S_REQ : S_DROP;
        // A single-flit packet can finish in the first granted cycle.
        S_REQ: begin
          if (fwd_pop[i] && head_last[i]) state_nx[i] = S_IDLE;
          else if (grant_valid[route_reg[i]] && grant_idx[route_reg[i]] == CW'(i))
            state_nx[i] = S_FWD;
        end
        S_FWD:  if (fwd_pop[i] && head_last[i]) state_nx[i] = S_IDLE;
        S_DROP: if (!fifo_empty[i] && head_last[i]) state_nx[i] = S_IDLE;
        default: state_nx[i] = S_IDLE;
      endcase
    end

    // An IDLE input requests straight from the combinational route so the
    // arbiter can grant one cycle after the header reaches the head.
    assign want[i]     = (state[i] == S_IDLE && !fifo_empty[i] && route_ok[i]) ||
                         state[i] == S_REQ || state[i] == S_FWD;
    assign want_dir[i] = (state[i] == S_IDLE) ? route_dir[i] : route_reg[i];
  end

  // ------------------------------------------------------------------
  // Crossbar datapath
  // ------------------------------------------------------------------
  always_comb begin
    out_tvalid = '0;
    out_tlast  = '0;
    out_tdata  = '0;
    for (int o = 0; o < CN; o++) begin
      if (grant_valid[o]) begin
        out_tvalid[o]                           = !fifo_empty[grant_idx[o]];
        out_tlast[o]                            = head_last[grant_idx[o]];
        out_tdata[o*DATA_WIDTH +: DATA_WIDTH]   = head_data[grant_idx[o]];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CN; i++) begin
      fwd_pop[i] = 1'b0;
      for (int o = 0; o < CN; o++) begin
        if (grant_valid[o] && grant_idx[o] == i[CW-1:0] && out_tvalid[o] && out_tready[o])
          fwd_pop[i] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-output wormhole arbiters
  // ------------------------------------------------------------------
  always_comb begin
    for (int o = 0; o < CN; o++) begin
      req[o] = '0;
      for (int i = 0; i < CN; i++) begin
        if (want[i] && want_dir[i] == o[CW-1:0]) req[o][i] = 1'b1;
      end
      pick[o] = rr_pick(req[o], rr_ptr[o]);
    end
  end

  // The grant drops on the TLAST transfer; the next winner is chosen in the
  // following cycle, which leaves a one-cycle bubble between packets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < CN; o++) begin
        grant_valid[o] <= 1'b0;
        grant_idx[o]   <= '0;
        rr_ptr[o]      <= '0;
      end
    end else begin
      for (int o = 0; o < CN; o++) begin
        if (grant_valid[o]) begin
          if (out_tvalid[o] && out_tready[o] && out_tlast[o]) grant_valid[o] <= 1'b0;
        end else if (pick[o][CW]) begin
          grant_valid[o] <= 1'b1;
          grant_idx[o]   <= pick[o][CW-1:0];
          rr_ptr[o]      <= pick[o][CW-1:0];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Drop counter; several inputs may finish a drop in the same cycle
  // ------------------------------------------------------------------
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < CN; i++) begin
      if (state[i] == S_DROP && !fifo_empty[i] && head_last[i]) drop_inc = drop_inc + (CW+1)'(1);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)           drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                  drop_cnt <= drop_sum[15:0];
  end

endmodule

// File: tb/tb_xy_wormhole_router.sv
// tb/tb_xy_wormhole_router.sv - self-checking bench for xy_wormhole_router at mesh position (1,1)

module tb_xy_wormhole_router;

  localparam int DW = 32;
  localparam int CN = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [CN*DW-1:0]   in_tdata;
  logic [CN-1:0]      in_tlast;
  logic [CN-1:0]      in_tvalid;
  logic [CN-1:0]      in_tready;
  logic [CN*DW-1:0]   out_tdata;
  logic [CN-1:0]      out_tlast;
  logic [CN-1:0]      out_tvalid;
  logic [CN-1:0]      out_tready;
  logic [15:0]        drop_cnt;

  always #5 clk = ~clk;

  xy_wormhole_router #(
    .DATA_WIDTH(32), .LOCAL_PORTS(1), .BUFFER_LENGTH(16),
    .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } flit_t;

  typedef struct {
    int src;
    int x;
    int y;
    int l;
    int n;
    int dst;   // -1: packet must be dropped
  } route_vec_t;

  flit_t      src_q [CN][$];
  flit_t      exp_q [CN][$];
  route_vec_t tbl [12];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pkt_id = 1;
  int exp_drop = 0;
  int acc_cnt [CN];
  int xfer_cnt [CN];
  int first_cyc [CN];
  int last_cyc [CN];
  int log_port = -1;
  int xfer_log [$];
  logic [CN-1:0] ready_mask;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_pkt(input int src, input int x, input int y, input int l, input int n, input int dst);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      if (k == 0) f.d = {27'(pkt_id), 1'(l), 2'(y), 2'(x)};
      else        f.d = {4'(src), 12'(pkt_id), 16'(k)};
      f.last = (k == n - 1);
      src_q[src].push_back(f);
      if (dst >= 0) exp_q[dst].push_back(f);
    end
    pkt_id++;
  endtask

  task automatic clear_stats();
    for (int c = 0; c < CN; c++) begin
      acc_cnt[c] = 0;
      xfer_cnt[c] = 0;
      first_cyc[c] = -1;
      last_cyc[c] = -1;
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, retire accepted flits.
  task automatic cycle();
    logic [CN-1:0] acc;
    flit_t         e;
    for (int c = 0; c < CN; c++) begin
      if (src_q[c].size() > 0) begin
        in_tvalid[c] = 1'b1;
        in_tdata[c*DW +: DW] = src_q[c][0].d;
        in_tlast[c] = src_q[c][0].last;
      end else begin
        in_tvalid[c] = 1'b0;
        in_tdata[c*DW +: DW] = '0;
        in_tlast[c] = 1'b0;
      end
    end
    out_tready = ready_mask;
    @(negedge clk);
    acc = in_tvalid & in_tready;
    if (rst_n) begin
      for (int o = 0; o < CN; o++) begin
        if (out_tvalid[o] && out_tready[o]) begin
          if (exp_q[o].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out%0d_unexpected got=%0h exp=none", o, out_tdata[o*DW +: DW]);
          end else begin
            e = exp_q[o].pop_front();
            check($sformatf("out%0d_data", o), out_tdata[o*DW +: DW], e.d);
            check($sformatf("out%0d_last", o), 32'(out_tlast[o]), 32'(e.last));
          end
          xfer_cnt[o]++;
          if (first_cyc[o] < 0) first_cyc[o] = cyc;
          last_cyc[o] = cyc;
          if (o == log_port) xfer_log.push_back(cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < CN; c++) begin
      if (acc[c]) begin
        void'(src_q[c].pop_front());
        acc_cnt[c]++;
      end
    end
    cyc++;
  endtask

  function automatic bit busy();
    for (int c = 0; c < CN; c++) begin
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && busy()) begin
      cycle();
      n++;
    end
    checks++;
    if (busy()) begin
      failures++;
      $display("FAIL %s_drain got=timeout after %0d cycles exp=all flits delivered", name, n);
      for (int c = 0; c < CN; c++) begin
        src_q[c].delete();
        exp_q[c].delete();
      end
    end
    repeat (8) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int offs [6];
    // Router (1,1) in a 4x4 mesh.
    tbl[0]  = '{src: 4, x: 3, y: 1, l: 0, n: 3, dst: 2};
    tbl[1]  = '{src: 4, x: 0, y: 2, l: 0, n: 2, dst: 3};
    tbl[2]  = '{src: 0, x: 1, y: 3, l: 0, n: 2, dst: 1};
    tbl[3]  = '{src: 1, x: 1, y: 0, l: 0, n: 1, dst: 0};
    tbl[4]  = '{src: 2, x: 1, y: 1, l: 0, n: 2, dst: 4};
    tbl[5]  = '{src: 1, x: 2, y: 2, l: 0, n: 2, dst: 2};
    tbl[6]  = '{src: 3, x: 1, y: 1, l: 1, n: 4, dst: -1};  // local index out of range
    tbl[7]  = '{src: 3, x: 1, y: 1, l: 0, n: 2, dst: 4};   // same input recovers
    tbl[8]  = '{src: 4, x: 1, y: 1, l: 0, n: 2, dst: -1};  // U-turn on LOCAL
    tbl[9]  = '{src: 2, x: 3, y: 0, l: 0, n: 3, dst: -1};  // U-turn on EAST
    tbl[10] = '{src: 0, x: 1, y: 0, l: 0, n: 1, dst: -1};  // single-flit U-turn on NORTH
    tbl[11] = '{src: 1, x: 1, y: 2, l: 0, n: 2, dst: -1};  // U-turn on SOUTH
    offs = '{2, 3, 5, 6, 8, 9};

    rst_n = 1'b0;
    in_tdata = '0;
    in_tlast = '0;
    in_tvalid = '0;
    ready_mask = '1;
    out_tready = '1;
    clear_stats();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_tready", 32'(in_tready), 32'd0);
    check("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_tready", 32'(in_tready), 32'h1F);
    @(posedge clk);
    #1;

    // Route table, one packet at a time
    for (int t = 0; t < 12; t++) begin
      send_pkt(tbl[t].src, tbl[t].x, tbl[t].y, tbl[t].l, tbl[t].n, tbl[t].dst);
      drain($sformatf("tbl%0d", t), 200);
      if (tbl[t].dst < 0) exp_drop++;
      check($sformatf("tbl%0d_drop_cnt", t), 32'(drop_cnt), 32'(exp_drop));
    end

    // Latency: accepted in cycle N, out_tvalid at N+2, then 1 flit/cycle
    clear_stats();
    n0 = cyc;
    send_pkt(4, 3, 1, 0, 3, 2);
    drain("latency", 100);
    check("lat_first", 32'(first_cyc[2]), 32'(n0 + 2));
    check("lat_last", 32'(last_cyc[2]), 32'(n0 + 4));
    check("lat_count", 32'(xfer_cnt[2]), 32'd3);

    // Two packets to different outputs stream concurrently
    clear_stats();
    n0 = cyc;
    send_pkt(0, 1, 1, 0, 4, 4);
    send_pkt(2, 1, 3, 0, 4, 1);
    drain("concurrent", 100);
    check("conc_local_first", 32'(first_cyc[4]), 32'(n0 + 2));
    check("conc_local_last", 32'(last_cyc[4]), 32'(n0 + 5));
    check("conc_south_first", 32'(first_cyc[1]), 32'(n0 + 2));
    check("conc_south_last", 32'(last_cyc[1]), 32'(n0 + 5));

    // Leave WEST (ch3) as last LOCAL winner so the next search starts at ch4 and wraps to ch0.
    send_pkt(3, 1, 1, 0, 1, 4);
    drain("warmup", 100);

    // Three inputs contend for LOCAL: ch0, ch1, ch3 with a bubble between packets
    clear_stats();
    log_port = 4;
    xfer_log.delete();
    n0 = cyc;
    send_pkt(0, 1, 1, 0, 2, 4);
    send_pkt(1, 1, 1, 0, 2, 4);
    send_pkt(3, 1, 1, 0, 2, 4);
    drain("arb", 200);
    check("arb_count", 32'(xfer_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < xfer_log.size()) check($sformatf("arb_cycle%0d", k), 32'(xfer_log[k]), 32'(n0 + offs[k]));
    end
    log_port = -1;

    // Backpressure on EAST fills the LOCAL FIFO; SOUTH keeps flowing
    clear_stats();
    ready_mask[2] = 1'b0;
    send_pkt(4, 3, 1, 0, 20, 2);
    send_pkt(0, 1, 3, 0, 3, 1);
    repeat (20) cycle();
    check("bp_accepted", 32'(acc_cnt[4]), 32'd16);
    check("bp_in_tready", 32'(in_tready[4]), 32'd0);
    check("bp_east_xfers", 32'(xfer_cnt[2]), 32'd0);
    check("bp_east_valid", 32'(out_tvalid[2]), 32'd1);
    check("bp_south_xfers", 32'(xfer_cnt[1]), 32'd3);
    ready_mask[2] = 1'b1;
    drain("backpressure", 200);
    check("bp_east_total", 32'(xfer_cnt[2]), 32'd20);

    // Reset in the middle of a packet
    clear_stats();
    send_pkt(4, 3, 1, 0, 6, 2);
    repeat (3) cycle();
    rst_n = 1'b0;
    src_q[4].delete();
    exp_q[2].delete();
    #1;
    check("midrst_in_tready", 32'(in_tready), 32'd0);
    cycle();
    rst_n = 1'b1;
    exp_drop = 0;
    #1;
    check("midrst_out_tvalid", 32'(out_tvalid), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("midrst_in_tready_rel", 32'(in_tready), 32'h1F);
    @(posedge clk);
    #1;
    clear_stats();
    send_pkt(4, 3, 1, 0, 2, 2);
    drain("after_reset", 100);
    check("after_rst_count", 32'(xfer_cnt[2]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
